// File: rtl/mc_pkg.sv
// Shared definitions for the 12-bit microcontroller: loader FSM states,
// instruction width and pipeline stage encodings.
package mc_pkg;

    localparam int unsigned InstrW = 12;

    typedef enum logic [2:0] {
        LdIdle,
        LdLen,
        LdHi,
        LdLo,
        LdWrite,
        LdCsum,
        LdDone,
        LdErr
    } ld_state_e;

    // The stage sequencer only pulses the loader's start while in StageLoad.
    typedef enum logic [1:0] {
        StageLoad    = 2'b00,
        StageFetch   = 2'b01,
        StageDecode  = 2'b10,
        StageExecute = 2'b11
    } stage_e;

endpackage

// File: rtl/pmem_loader.sv
// Program-memory loader: receives a LEN / (HI,LO)* / CSUM byte frame, writes
// 12-bit words to consecutive addresses from 0 and verifies the checksum.
module pmem_loader
    import mc_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              pmem_we,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [InstrW-1:0] pmem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        rem_q, rem_d;
    logic [3:0]        hi_q, hi_d;
    logic [InstrW-1:0] wdata_q, wdata_d;
    logic              accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LdIdle;
            addr_q  <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sum_d     = sum_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        wdata_d   = wdata_q;
        in_ready  = 1'b0;
        pmem_we   = 1'b0;
        busy      = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;

        unique case (state_q)
            LdLen, LdHi, LdLo, LdCsum: in_ready = 1'b1;
            default:                   in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;

        case (state_q)
            LdIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d = LdLen;
                    addr_d  = '0;
                    sum_d   = '0;
                end
            end
            LdLen: begin
                if (accept) begin
                    if (in_data == 8'd0) begin
                        state_d = LdErr;
                    end else begin
                        rem_d   = in_data;
                        state_d = LdHi;
                    end
                end
            end
            LdHi: begin
                if (accept) begin
                    if (in_data[7:4] != 4'd0) begin
                        state_d = LdErr;
                    end else begin
                        hi_d    = in_data[3:0];
                        sum_d   = sum_q + in_data;
                        state_d = LdLo;
                    end
                end
            end
            LdLo: begin
                if (accept) begin
                    wdata_d = {hi_q, in_data};
                    sum_d   = sum_q + in_data;
                    state_d = LdWrite;
                end
            end
            LdWrite: begin
                pmem_we = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - 8'd1;
                // rem_q counts words still to write, including this one
                state_d = (rem_q == 8'd1) ? LdCsum : LdHi;
            end
            LdCsum: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? LdDone : LdErr;
                end
            end
            LdDone, LdErr: begin
                busy      = 1'b0;
                load_done = (state_q == LdDone);
                load_err  = (state_q == LdErr);
                if (start) begin
                    state_d = LdLen;
                    addr_d  = '0;
                    sum_d   = '0;
                end
            end
            default: state_d = LdIdle;
        endcase
    end

    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;

endmodule

// File: doc/pmem_loader.md
# pmem_loader

Program-memory loader for the 12-bit microcontroller: it writes program memory so the control path can fetch from it. During the LOAD stage it accepts a framed byte stream over a valid/ready handshake. It packs byte pairs into 12-bit instruction words, writes them to consecutive program-memory addresses from 0, and verifies a trailing checksum. It reports done or error to the stage sequencer, which may leave LOAD only after done.

## Interface
- ADDR_W, 8, program-memory address width; frame length is limited to 255 words
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load; ignored while busy
- in_valid  in  1  in_data holds a byte
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- pmem_we  out  1  program-memory write strobe, one cycle per word
- pmem_addr  out  ADDR_W  write address
- pmem_wdata  out  12  instruction word
- busy  out  1  load in progress
- load_done  out  1  frame loaded and checksum good; held until next start
- load_err  out  1  frame rejected; held until next start

## Operation
- Frame format, in order:
  - LEN byte N, the word count, 1..255.
  - N pairs, each HI then LO. HI[7:4] must be 0; HI[3:0] is word[11:8] and LO is word[7:0].
  - CSUM byte, which must equal the mod-256 sum of all HI and LO bytes (LEN excluded).
- A byte is accepted only on a cycle where in_valid && in_ready.
- FSM states and transitions:
  - IDLE: on start, go to LEN; clear addr, sum, load_done and load_err.
  - LEN: on accept, if N==0 go to ERR, else latch N and go to HI.
  - HI: on accept, if HI[7:4]!=0 go to ERR, else latch the nibble, add to sum, go to LO.
  - LO: on accept, form the word, add to sum, go to WRITE.
  - WRITE: pmem_we=1 for exactly one cycle; then increment addr. Go to CSUM if this was word N, else go to HI.
  - CSUM: on accept, go to DONE if the byte equals sum, else go to ERR.
  - DONE: load_done=1; on start, go to LEN.
  - ERR: load_err=1; on start, go to LEN.
- in_ready=1 only in LEN, HI, LO and CSUM.
- busy=1 in every state except IDLE, DONE and ERR.
- Words already written before an error are not rolled back. load_err tells the sequencer not to run.
- The sum is 8 bits and wraps modulo 256.
- addr starts at 0 and never wraps within a frame, because N ≤ 255.

## Timing
- Reset values: in_ready=0, pmem_we=0, pmem_addr=0, pmem_wdata=0, busy=0, load_done=0, load_err=0; state=IDLE.
- start is registered: in_ready rises on the cycle after start.
- The write strobe is on the cycle after LO is accepted, with addr and wdata stable during it. Address k+1 is presented on the cycle after the strobe for word k.
- Peak throughput is one word per 3 cycles. Stalls (in_valid=0) hold the state indefinitely with no timeout.
- load_done and load_err go high on the cycle after CSUM is accepted (or after the failing byte). They clear on the cycle after the next accepted start.
- start while busy has no effect.
- Reset mid-frame returns to IDLE on the next edge with all outputs at reset values. Program memory keeps partial contents.
- in_valid held high with no frame active is ignored; in_ready stays 0.

## Structure
- Shared package mc_pkg holds:
  - the loader state enum (IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR);
  - the instruction width constant 12;
  - the stage encodings LOAD=00, FETCH=01, DECODE=10, EXECUTE=11, which the sequencer uses to gate start.
- Implemented as a single module with no sub-module. The checksum accumulator and word packer are a few registers inside the FSM.

## Test plan
- Basic frame: start, then 02 08 A5 01 23 D1 at full rate. Required: two writes, addr0=0x8A5 and addr1=0x123, 3 cycles apart. load_done=1 on the cycle after the D1 byte; load_err=0.
- Bad checksum: the same frame with CSUM=D0. Required: both writes occur, load_err=1, load_done=0.
- Bad HI nibble: 01 18 00 .. Required: ERR on accept of 0x18, no pmem_we, in_ready=0 afterwards.
- Zero length: LEN=00. Required: load_err=1, no writes.
- Stalls and backpressure: the basic frame with in_valid randomly low 50% of cycles. Required: same writes and result. in_ready=0 during WRITE, with no byte lost or duplicated.
- Boundary and control cases:
  - Full frame of N=255 ending at addr 254; checksum wrap checked.
  - start pulsed while busy is ignored.
  - rst asserted after the 3rd word returns all outputs to 0 next cycle; a following start reloads from addr 0.
